truth_table_checker: RTL and testbench

- Synthesizable, self-checking exhaustive sweeper for N-input single-output combinational gates.
- On `start`, drives every input vector 0 to 2^N−1 onto `stim` and holds each vector for SETTLE cycles.
- At the end of each hold, samples the gate output `dut_y` and compares it with the expected truth table passed in as a parameter.
- Reports mismatch count, first failing vector and pass/fail; used to sign off gate-level blocks in hardware and in simulation.

---
 rtl/truth_table_checker.sv | 110 +++++++++++
 tb/tb_truth_table_checker.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table sweeper for an N-input, single-output gate.
// Define TTC_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module truth_table_checker #(
    parameter int                N      = 3,
    parameter logic [(1<<N)-1:0] TRUTH  = 8'h15,
    parameter int                SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         dut_y,
    output logic [N-1:0] stim,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic         fail_seen,
    output logic [N-1:0] first_fail_vec
);

    localparam int CW = $clog2(SETTLE) + 1;
    localparam logic [N-1:0] LAST = {N{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [N-1:0]    stim_q;
    logic [CW-1:0]   cnt_q;
    logic [N:0]      err_q;
    logic            fail_q;
    logic [N-1:0]    ffv_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;

    logic            sample;
    logic            mismatch;
    logic            stop;
    logic [N:0]      err_d;

    assign sample   = (state_q == RUN) && (cnt_q == CW'(SETTLE - 1));
    assign mismatch = sample && (dut_y != TRUTH[stim_q]);
    assign err_d    = err_q + {{N{1'b0}}, mismatch};

`ifdef TTC_STOP_ON_FAIL_EN
    assign stop = (stim_q == LAST) || mismatch;
`else
    assign stop = (stim_q == LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stim_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fail_q  <= 1'b0;
            ffv_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        stim_q  <= '0;
                        cnt_q   <= '0;
                        err_q   <= '0;
                        fail_q  <= 1'b0;
                        ffv_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!sample) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        err_q <= err_d;
                        if (mismatch && !fail_q) begin
                            fail_q <= 1'b1;
                            ffv_q  <= stim_q;
                        end
                        if (stop) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            stim_q <= stim_q + N'(1);
                            cnt_q  <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim           = stim_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_seen      = fail_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: vector table plus
// hand-written SETTLE=3, busy-start and mid-sweep reset sequences.
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic       y1, y3;
    logic [2:0] stim1, stim3;
    logic       busy1, busy3, done1, done3, pass1, pass3;
    logic [3:0] err1, err3;
    logic       fs1, fs3;
    logic [2:0] ffv1, ffv3;
    int         mode1 = 0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    truth_table_checker #(.N(3), .TRUTH(8'h15), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_y(y1),
        .stim(stim1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_seen(fs1), .first_fail_vec(ffv1)
    );

    truth_table_checker #(.N(3), .TRUTH(8'h15), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .dut_y(y3),
        .stim(stim3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_seen(fs3), .first_fail_vec(ffv3)
    );

    // mode: 0 good, 1 stuck0, 2 stuck1, 3 inverted, 4 wrong at 6
    function automatic logic model(logic [2:0] s, int mode);
        logic g;
        g = ~((s[2] & s[1]) | s[0]);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~g;
            4:       return g ^ (s == 3'd6);
            default: return g;
        endcase
    endfunction

    assign y1 = model(stim1, mode1);
    assign y3 = model(stim3, 0);

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int mode;
        int cyc;
        int err;
        int ffv;
        int fs;
        int stimf;
        int ps;
    } vec_t;

    vec_t tbl[6];

    task automatic sweep1(vec_t r);
        mode1  = r.mode;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("clr_err", int'(err1), 0);
        chk("clr_fs", int'(fs1), 0);
        chk("clr_ffv", int'(ffv1), 0);
        chk("clr_done", int'(done1), 0);
        for (int k = 0; k < r.cyc; k++) begin
            chk("run_stim", int'(stim1), k);
            chk("run_busy", int'(busy1), 1);
            step();
        end
        chk("end_done", int'(done1), 1);
        chk("end_busy", int'(busy1), 0);
        chk("end_err", int'(err1), r.err);
        chk("end_ffv", int'(ffv1), r.ffv);
        chk("end_fs", int'(fs1), r.fs);
        chk("end_pass", int'(pass1), r.ps);
        chk("end_stim", int'(stim1), r.stimf);
        step();
        step();
        chk("hold_done", int'(done1), 1);
        chk("hold_err", int'(err1), r.err);
        chk("hold_stim", int'(stim1), r.stimf);
    endtask

    initial begin
        tbl[0] = '{0, 8, 0, 0, 0, 7, 1};
`ifdef TTC_STOP_ON_FAIL_EN
        tbl[1] = '{1, 1, 1, 0, 1, 0, 0};
        tbl[2] = '{2, 2, 1, 1, 1, 1, 0};
        tbl[3] = '{3, 1, 1, 0, 1, 0, 0};
        tbl[4] = '{4, 7, 1, 6, 1, 6, 0};
`else
        tbl[1] = '{1, 8, 3, 0, 1, 7, 0};
        tbl[2] = '{2, 8, 5, 1, 1, 7, 0};
        tbl[3] = '{3, 8, 8, 0, 1, 7, 0};
        tbl[4] = '{4, 8, 1, 6, 1, 7, 0};
`endif
        tbl[5] = '{0, 8, 0, 0, 0, 7, 1};

        #12;
        chk("rst_stim", int'(stim1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        chk("rst_pass", int'(pass1), 0);
        chk("rst_err", int'(err1), 0);
        chk("rst_fs", int'(fs1), 0);
        chk("rst_ffv", int'(ffv1), 0);
        rst = 1'b0;
        step();
        step();
        chk("idle_busy", int'(busy1), 0);

        for (int i = 0; i < 6; i++) sweep1(tbl[i]);

        // SETTLE=3 sweep with a start pulse while busy
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 3; c++) begin
                chk("s3_stim", int'(stim3), k);
                chk("s3_busy", int'(busy3), 1);
                start3 = (k == 2 && c == 1);
                step();
                start3 = 1'b0;
            end
        end
        chk("s3_done", int'(done3), 1);
        chk("s3_pass", int'(pass3), 1);
        chk("s3_err", int'(err3), 0);

        // asynchronous reset with stim=4 and errors accumulated
        mode1  = 1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("pre_rst_stim", int'(stim1), 4);
        chk("pre_rst_err", int'(err1), 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_stim", int'(stim1), 0);
        chk("ar_err", int'(err1), 0);
        chk("ar_busy", int'(busy1), 0);
        chk("ar_done", int'(done1), 0);
        chk("ar_fs", int'(fs1), 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_busy", int'(busy1), 0);
        sweep1(tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
